// File: rtl/and1_xor1.sv
// Single-entry registered half-adder stage. Each accepted operand pair yields a
// per-bit sum (XOR) and carry (AND) one clock later, with a count of accepted pairs.
module and1_xor1 #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y_xor,
   output logic [WIDTH-1:0] y_and,
   output logic [CNT_W-1:0] op_count
);

   logic             vld_p1;
   logic [WIDTH-1:0] xor_p1;
   logic [WIDTH-1:0] and_p1;
   logic [CNT_W-1:0] cnt_p1;
   logic             accept_p0;

   // Per-bit half adder: no carry ever crosses a bit boundary.
   function automatic logic [WIDTH-1:0] half_sum(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
      return x ^ y;
   endfunction

   function automatic logic [WIDTH-1:0] half_carry(input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y);
      return x & y;
   endfunction

   // The slot is free when empty or being drained this cycle.
   always_comb begin
      in_ready  = !vld_p1 || out_ready;
      accept_p0 = in_valid && in_ready;
   end

   // p0 -> p1 boundary
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         xor_p1 <= '0;
         and_p1 <= '0;
         cnt_p1 <= '0;
      end else if (accept_p0) begin
         vld_p1 <= 1'b1;
         xor_p1 <= half_sum(a, b);
         and_p1 <= half_carry(a, b);
         cnt_p1 <= cnt_p1 + CNT_W'(1);
      end else if (out_ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign out_valid = vld_p1;
   assign y_xor     = xor_p1;
   assign y_and     = and_p1;
   assign op_count  = cnt_p1;

endmodule

// File: tb/tb_and1_xor1.sv
// Randomized bench for and1_xor1 with a per-bit half-adder reference model,
// plus directed literal cases for the 1-bit truth table, backpressure, reset and wrap.
module tb_and1_xor1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, out_ready;
   logic [7:0] a, b;
   logic       in_ready, out_valid;
   logic [7:0] y_xor, y_and;
   logic [3:0] op_count;

   logic        w1_valid, w1_ready_in, w1_a, w1_b;
   logic        w1_in_ready, w1_out_valid, w1_y_xor, w1_y_and;
   logic [15:0] w1_count;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   // Reference model state
   bit       m_vld = 1'b0;
   bit [7:0] m_xor = '0;
   bit [7:0] m_and = '0;
   int       m_cnt = 0;

   always #5 clk = ~clk;

   and1_xor1 #(.WIDTH(8), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .y_xor(y_xor), .y_and(y_and), .op_count(op_count)
   );

   and1_xor1 dut_w1 (
      .clk(clk), .rst_n(rst_n), .in_valid(w1_valid), .in_ready(w1_in_ready),
      .a(w1_a), .b(w1_b), .out_valid(w1_out_valid), .out_ready(w1_ready_in),
      .y_xor(w1_y_xor), .y_and(w1_y_and), .op_count(w1_count)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   // Model: a transaction is taken when valid meets a free or draining slot;
   // each result bit is the two-bit sum of the operand bits split into sum/carry.
   always @(posedge clk) begin
      bit acc;
      int s;
      acc = in_valid && (!m_vld || out_ready);
      if (!rst_n) begin
         m_vld = 1'b0;
         m_xor = '0;
         m_and = '0;
         m_cnt = 0;
      end else if (acc) begin
         for (int i = 0; i < 8; i++) begin
            s = int'(a[i]) + int'(b[i]);
            m_xor[i] = (s % 2) == 1;
            m_and[i] = (s / 2) == 1;
         end
         m_vld = 1'b1;
         m_cnt = (m_cnt + 1) % 16;
      end else if (out_ready) begin
         m_vld = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("out_valid", 64'(out_valid), 64'(m_vld));
         chk("in_ready", 64'(in_ready), 64'(!m_vld || out_ready));
         chk("y_xor", 64'(y_xor), 64'(m_xor));
         chk("y_and", 64'(y_and), 64'(m_and));
         chk("op_count", 64'(op_count), 64'(m_cnt));
      end
   end

   initial begin
      logic [1:0] tt_x [4];
      logic [1:0] tt_a [4];
      logic [7:0] pa, pb;
      logic [3:0] c0;
      tt_x[0] = 2'b00; tt_x[1] = 2'b10; tt_x[2] = 2'b10; tt_x[3] = 2'b01;
      tt_a[0] = 2'b00; tt_a[1] = 2'b01; tt_a[2] = 2'b10; tt_a[3] = 2'b11;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      w1_valid = 1'b0; w1_ready_in = 1'b1; w1_a = 1'b0; w1_b = 1'b0;
      cyc(); cyc();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_y_xor", 64'(y_xor), 64'd0);
      chk("rst_y_and", 64'(y_and), 64'd0);
      chk("rst_op_count", 64'(op_count), 64'd0);
      chk("rst_in_ready_low_rst", 64'(in_ready), 64'd1);
      rst_n = 1'b1;
      mon_en = 1'b1;

      // 1-bit truth table, one result per cycle
      w1_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         w1_a = tt_a[i][1];
         w1_b = tt_a[i][0];
         cyc();
         chk("w1_y_xor", 64'(w1_y_xor), 64'(tt_x[i][1]));
         chk("w1_y_and", 64'(w1_y_and), 64'(tt_x[i][0]));
         chk("w1_out_valid", 64'(w1_out_valid), 64'd1);
      end
      w1_valid = 1'b0;
      chk("w1_op_count", 64'(w1_count), 64'd4);

      // 8-bit literal
      in_valid = 1'b1; a = 8'hF0; b = 8'h3C; out_ready = 1'b1;
      cyc();
      chk("lit_y_xor", 64'(y_xor), 64'hCC);
      chk("lit_y_and", 64'(y_and), 64'h30);
      chk("lit_out_valid", 64'(out_valid), 64'd1);
      in_valid = 1'b0;
      cyc();
      chk("drain_out_valid", 64'(out_valid), 64'd0);
      chk("drain_y_xor_kept", 64'(y_xor), 64'hCC);

      // Backpressure
      in_valid = 1'b1; a = 8'h12; b = 8'h34; out_ready = 1'b0;
      cyc();
      a = 8'hFF; b = 8'h0F;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_y_xor", 64'(y_xor), 64'h26);
         chk("bp_y_and", 64'(y_and), 64'h10);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 64'(in_ready), 64'd1);
      cyc();
      chk("bp_new_xor", 64'(y_xor), 64'hF0);
      chk("bp_new_and", 64'(y_and), 64'h0F);
      in_valid = 1'b0;
      cyc();

      // Reset with a pending result
      in_valid = 1'b1; a = 8'hAA; b = 8'h55; out_ready = 1'b0;
      cyc();
      chk("pend_out_valid", 64'(out_valid), 64'd1);
      rst_n = 1'b0;
      cyc();
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_y_xor", 64'(y_xor), 64'd0);
      chk("mid_rst_y_and", 64'(y_and), 64'd0);
      chk("mid_rst_op_count", 64'(op_count), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      rst_n = 1'b1; in_valid = 1'b0;
      cyc();

      // Wrap: 17 back-to-back acceptances on a 4-bit counter
      out_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         a = 8'($urandom); b = 8'($urandom);
         cyc();
      end
      in_valid = 1'b0;
      chk("wrap_op_count", 64'(op_count), 64'd1);
      cyc();

      // Streaming: 8 cycles, each result from the previous cycle's operands
      c0 = op_count;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         pa = 8'($urandom); pb = 8'($urandom);
         a = pa; b = pb;
         cyc();
         chk("stream_out_valid", 64'(out_valid), 64'd1);
         chk("stream_y_xor", 64'(y_xor), 64'(pa ^ pb));
         chk("stream_y_and", 64'(y_and), 64'(pa & pb));
      end
      in_valid = 1'b0;
      chk("stream_count", 64'(op_count), 64'(4'(c0 + 4'd8)));

      // Random traffic with occasional reset
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         a = 8'($urandom); b = 8'($urandom);
         rst_n = ($urandom_range(0, 63) != 0);
         cyc();
      end
      rst_n = 1'b1; in_valid = 1'b0;
      cyc();
      mon_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
